sort_serializer: RTL and testbench
==================================

SORT_SERIALIZER -- requirements
Module: sort_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 4: width in bits of one key.
REQ-002 Parameter NUM_INPUTS, default 8: number of keys per sorted vector, power of two, at least 2.
REQ-003 Parameter ASCENDING, default 1: expected key order, used only by the order checker (1 = non-decreasing, 0 = non-increasing).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 x_valid  input  1  sorted vector present on x_data from the comparator network's last stage.
REQ-007 x_data  input  NUM_INPUTS*DATA_WIDTH  sorted vector; key i occupies bits [i*DATA_WIDTH +: DATA_WIDTH], key 0 is emitted first.
REQ-008 x_ready  output  1  block can capture a vector this cycle.
REQ-009 y_data  output  DATA_WIDTH  current serial key.
REQ-010 y_valid  output  1  y_data holds a valid key.
REQ-011 y_ready  input  1  downstream accepts y_data this cycle.
REQ-012 y_last  output  1  current key is key NUM_INPUTS-1 of its vector.
REQ-013 overflow  output  1  sticky: a vector arrived while x_ready was 0 and was dropped.
REQ-014 order_err  output  1  sticky: an emitted key violated ASCENDING order.

Function
REQ-015 The block SHALL be a two-state FSM with states IDLE and STREAM, plus a vector buffer and an index counter of clog2(NUM_INPUTS) bits.
REQ-016 IDLE: x_ready=1 and y_valid=0; when x_valid=1, the block SHALL capture x_data, clear the index to 0, and move to STREAM.
REQ-017 Latency: y_valid SHALL assert on the cycle after capture, with y_data = key 0.
REQ-018 STREAM: y_valid=1 and y_data=buffer[index]; a transfer is y_valid & y_ready, and each transfer SHALL increment the index by 1.
REQ-019 While y_valid=1 and y_ready=0, y_data, y_last and the index SHALL hold stable.
REQ-020 y_last SHALL equal (state==STREAM && index==NUM_INPUTS-1).
REQ-021 On a transfer with y_last=1, the block SHALL return to IDLE unless a new vector is captured on the same cycle.
REQ-022 x_ready = IDLE | (STREAM & y_last & y_ready), a combinational path from y_ready; if x_valid=1 on that last-transfer cycle, the block SHALL capture, reset the index to 0 and stay in STREAM, giving back-to-back vectors with no bubble.
REQ-023 If x_valid=1 while x_ready=0, the vector SHALL be dropped, the stream in progress SHALL continue unaffected, and overflow SHALL set on the next edge.
REQ-024 overflow and order_err SHALL clear only by reset.
REQ-025 All key comparisons SHALL be unsigned; equal adjacent keys are legal in either order.

Reset
REQ-026 While rst=0: state=IDLE, index=0, buffer=0, y_data=0, y_valid=0, y_last=0, overflow=0, order_err=0; x_ready SHALL read 1 from the first edge after rst=1.
REQ-027 Reset asserted mid-stream SHALL abort the vector at once (y_valid drops asynchronously), and the remaining keys SHALL be lost.

Configuration
REQ-028 Macro SORT_SER_ORDER_CHECK_EN defined: on each transfer with index>0, the block SHALL compare y_data to the previously transferred key of the same vector, and on a violation of ASCENDING it SHALL set order_err on the next edge.
REQ-029 Macro SORT_SER_ORDER_CHECK_EN undefined: no checker logic or previous-key register SHALL exist, and order_err SHALL be tied to 0 (the port remains).

Verification
REQ-030 NUM_INPUTS=4, DATA_WIDTH=4, y_ready=1, vector {1,3,5,7} -> y_data 1,3,5,7 on four consecutive cycles starting one cycle after capture, with y_last=1 only with 7, then IDLE.
REQ-031 Same vector, y_ready=0 for 3 cycles while key 5 is shown -> y_data=5, y_valid=1 and y_last=0 all held for those 3 cycles, then 7 follows.
REQ-032 x_valid pulsed while key 3 is shown -> no capture, stream finishes 5,7, overflow=1 and stays 1 until rst=0.
REQ-033 Second vector {0,2,2,8} presented on the last-transfer cycle of the first -> key 0 follows 7 with no gap, overflow=0.
REQ-034 Macro defined, ASCENDING=1, vector {2,6,4,9} -> order_err=1 on the edge after the transfer of 4; macro undefined -> order_err stays 0.
REQ-035 rst=0 during the transfer of key 3 -> y_valid=0 immediately, and after release x_ready=1 and a new vector {9,9,9,9} streams cleanly.

Source files
------------

// File: rtl/sort_serializer_if.sv
// Handshake bundle for sort_serializer: the parallel sorted-vector input (x_*)
// and the serial key output (y_*).
interface sort_serializer_if #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_INPUTS = 8
);
  // valid/ready: a beat moves on a rising edge where valid & ready are both 1.
  // The producer holds data and valid stable until that edge. x_ready is
  // combinational from y_ready, so a new vector can land on the last-key cycle.
  logic                             x_valid;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] x_data;
  logic                             x_ready;
  logic [DATA_WIDTH-1:0]            y_data;
  logic                             y_valid;
  logic                             y_ready;
  logic                             y_last;

  modport master (
    output x_valid, x_data, y_ready,
    input  x_ready, y_data, y_valid, y_last
  );

  modport slave (
    input  x_valid, x_data, y_ready,
    output x_ready, y_data, y_valid, y_last
  );
endinterface

// File: rtl/sort_serializer.sv
// Serializes one sorted vector per capture, key 0 first, with back-to-back capture
// on the final key. Define SORT_SER_ORDER_CHECK_EN to build the sticky order checker.
module sort_serializer #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_INPUTS = 8,
  parameter int ASCENDING  = 1
) (
  input  logic              clk,
  input  logic              rst,
  sort_serializer_if.slave  bus,
  output logic              overflow,
  output logic              order_err,
  output logic              state_dbg
);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] buf_q [NUM_INPUTS];
  logic                  at_last;
  logic                  xfer;
  logic                  capture;

  assign at_last   = (idx_q == LAST_IDX);
  assign xfer      = bus.y_valid & bus.y_ready;
  assign capture   = bus.x_valid & bus.x_ready;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus.x_ready = 1'b0;
    bus.y_valid = 1'b0;
    bus.y_last  = 1'b0;
    bus.y_data  = buf_q[idx_q];
    case (state_q)
      IDLE: begin
        bus.x_ready = 1'b1;
        if (bus.x_valid) state_d = STREAM;
      end
      STREAM: begin
        bus.y_valid = 1'b1;
        bus.y_last  = at_last;
        // The last handshake frees the buffer, so a waiting vector can refill it now.
        bus.x_ready = at_last & bus.y_ready;
        if (at_last && bus.y_ready && !bus.x_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) buf_q[i] <= '0;
    end else if (capture) begin
      idx_q <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) buf_q[i] <= bus.x_data[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (xfer) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            overflow <= 1'b0;
    else if (bus.x_valid && !bus.x_ready) overflow <= 1'b1;
  end

`ifdef SORT_SER_ORDER_CHECK_EN
  logic [DATA_WIDTH-1:0] prev_q;
  logic                  order_bad;

  // Key 0 of each vector has no predecessor, so it is never compared.
  always_comb begin
    order_bad = 1'b0;
    if (xfer && idx_q != '0)
      order_bad = (ASCENDING != 0) ? (bus.y_data < prev_q) : (bus.y_data > prev_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q    <= '0;
      order_err <= 1'b0;
    end else begin
      if (xfer)      prev_q    <= bus.y_data;
      if (order_bad) order_err <= 1'b1;
    end
  end
`else
  // ASCENDING only matters to the checker; without it the flag is a constant 0.
  assign order_err = 1'b0 & (ASCENDING != 0);
`endif
endmodule

// File: tb/tb_sort_serializer.sv
// Bench for sort_serializer: vector table, directed multi-cycle corners and a
// randomized run scored against a queue-based model of the key stream.
module tb_sort_serializer;
  localparam int DW = 4;
  localparam int N  = 4;
  localparam int W  = DW + 2;  // {first, last, key}
`ifdef SORT_SER_ORDER_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic overflow, order_err, state_dbg;

  always #5 clk = ~clk;

  sort_serializer_if #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) bus ();

  sort_serializer #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .ASCENDING(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .overflow  (overflow),
    .order_err (order_err),
    .state_dbg (state_dbg)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: every key still owed downstream, in emission order.
  logic [W-1:0]  exp_q[$];
  logic          m_ovf;
  logic          m_oerr;
  logic [DW-1:0] m_prev;

  typedef struct packed {
    logic [N*DW-1:0]      vec;
    logic [N-1:0][DW-1:0] k;
    logic                 oerr;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_vec(input logic [N*DW-1:0] v);
    for (int i = 0; i < N; i++)
      exp_q.push_back({(i == 0), (i == N - 1), v[i*DW +: DW]});
  endtask

  // One clock: compare outputs to the model at the negedge, advance the model, cross the edge.
  task automatic step();
    logic         m_valid, m_ready;
    logic [W-1:0] e;
    @(negedge clk);
    m_valid = (exp_q.size() > 0);
    m_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.y_ready);
    chk("x_ready", bus.x_ready, m_ready);
    chk("y_valid", bus.y_valid, m_valid);
    chk("overflow", overflow, m_ovf);
    chk("order_err", order_err, m_oerr);
    if (m_valid) begin
      chk("y_data", bus.y_data, exp_q[0][DW-1:0]);
      chk("y_last", bus.y_last, exp_q[0][DW]);
    end
    if (m_valid && bus.y_ready) begin
      e = exp_q.pop_front();
      if (CHK_EN && !e[DW+1] && e[DW-1:0] < m_prev) m_oerr = 1'b1;
      m_prev = e[DW-1:0];
    end
    if (bus.x_valid) begin
      if (m_ready) push_vec(bus.x_data);
      else         m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    bus.y_ready = 1'b1;
    exp_q.delete();
    m_ovf  = 1'b0;
    m_oerr = 1'b0;
    m_prev = '0;
    @(negedge clk);
    chk("rst_y_valid", bus.y_valid, 0);
    chk("rst_y_last", bus.y_last, 0);
    chk("rst_y_data", bus.y_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_order_err", order_err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N*DW-1:0] v);
    bus.x_valid = 1'b1;
    bus.x_data  = v;
    step();
    bus.x_valid = 1'b0;
  endtask

  function automatic logic [N*DW-1:0] rand_vec();
    logic [DW-1:0]   q[$];
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) q.push_back(DW'($urandom_range(0, (1 << DW) - 1)));
    if ($urandom_range(0, 3) != 0) q.sort();
    for (int i = 0; i < N; i++) v[i*DW +: DW] = q[i];
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{vec: 16'h7531, k: {4'd7, 4'd5, 4'd3, 4'd1}, oerr: 1'b0};
    tbl[1] = '{vec: 16'h8220, k: {4'd8, 4'd2, 4'd2, 4'd0}, oerr: 1'b0};
    tbl[2] = '{vec: 16'h9999, k: {4'd9, 4'd9, 4'd9, 4'd9}, oerr: 1'b0};
    tbl[3] = '{vec: 16'h9462, k: {4'd9, 4'd4, 4'd6, 4'd2}, oerr: CHK_EN};
    tbl[4] = '{vec: 16'h000F, k: {4'd0, 4'd0, 4'd0, 4'd15}, oerr: CHK_EN};
    tbl[5] = '{vec: 16'hF000, k: {4'd15, 4'd0, 4'd0, 4'd0}, oerr: 1'b0};

    // Table: capture, four keys on consecutive cycles, back to idle.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      bus.x_valid = 1'b1;
      bus.x_data  = tbl[t].vec;
      @(negedge clk);
      chk("tbl_x_ready", bus.x_ready, 1);
      chk("tbl_idle_y_valid", bus.y_valid, 0);
      @(posedge clk);
      #1;
      bus.x_valid = 1'b0;
      for (int j = 0; j < N; j++) begin
        @(negedge clk);
        chk("tbl_y_valid", bus.y_valid, 1);
        chk("tbl_y_data", bus.y_data, tbl[t].k[j]);
        chk("tbl_y_last", bus.y_last, (j == N - 1));
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      chk("tbl_end_y_valid", bus.y_valid, 0);
      chk("tbl_end_x_ready", bus.x_ready, 1);
      chk("tbl_order_err", order_err, tbl[t].oerr);
      chk("tbl_overflow", overflow, 0);
      @(posedge clk);
      #1;
    end

    // Stall on key 5 for three cycles.
    do_reset();
    send(16'h7531);
    step(); step();
    bus.y_ready = 1'b0;
    repeat (3) step();
    bus.y_ready = 1'b1;
    repeat (3) step();

    // Vector offered while key 3 is shown is dropped; overflow sticks.
    send(16'h7531);
    step();
    bus.x_valid = 1'b1;
    bus.x_data  = 16'hFFFF;
    step();
    bus.x_valid = 1'b0;
    repeat (4) step();
    chk("overflow_sticky", overflow, 1);

    // Back-to-back: second vector captured on the last-key cycle.
    do_reset();
    send(16'h7531);
    repeat (3) step();
    bus.x_valid = 1'b1;
    bus.x_data  = 16'h8220;
    step();
    bus.x_valid = 1'b0;
    repeat (5) step();

    // Reset during key 3 aborts the stream asynchronously.
    do_reset();
    send(16'h7531);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_y_valid", bus.y_valid, 0);
    chk("async_rst_y_data", bus.y_data, 0);
    exp_q.delete();
    m_ovf  = 1'b0;
    m_oerr = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(16'h9999);
    repeat (5) step();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.y_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        bus.x_valid = 1'b1;
        bus.x_data  = rand_vec();
      end else begin
        bus.x_valid = 1'b0;
      end
      step();
    end
    bus.x_valid = 1'b0;
    bus.y_ready = 1'b1;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
